// File: rtl/e203_subsys_tohost_pkg.sv
// e203_subsys_tohost_pkg: register offsets, STATUS bit positions and response FSM encoding
package e203_subsys_tohost_pkg;

    localparam logic [11:0] OFF_TOHOST   = 12'h000;
    localparam logic [11:0] OFF_FROMHOST = 12'h004;
    localparam logic [11:0] OFF_CYCLE    = 12'h008;
    localparam logic [11:0] OFF_STATUS   = 12'h00C;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_FAIL_BIT = 1;
    localparam int STATUS_CNT_LSB  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } rsp_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++)
            if (mask[i]) r[8*i +: 8] = new_val[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/e203_subsys_tohost.sv
// e203_subsys_tohost: ICB-attached tohost/fromhost test-end block with cycle counter
//   clk, rst             : core clock, asynchronous active-high reset
//   i_icb_cmd_*          : ICB command channel (valid/ready/addr/read/wdata/wmask)
//   i_icb_rsp_*          : ICB response channel (valid/ready/err/rdata), registered
//   o_done/o_pass        : sticky end-of-test flag and pass result
//   o_exit_code          : wdata[31:1] of the first ending TOHOST write
//   o_tohost_cnt         : saturating count of accepted full-word TOHOST writes
module e203_subsys_tohost
    import e203_subsys_tohost_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_icb_cmd_valid,
    output logic              i_icb_cmd_ready,
    input  logic [ADDR_W-1:0] i_icb_cmd_addr,
    input  logic              i_icb_cmd_read,
    input  logic [31:0]       i_icb_cmd_wdata,
    input  logic [3:0]        i_icb_cmd_wmask,
    output logic              i_icb_rsp_valid,
    input  logic              i_icb_rsp_ready,
    output logic              i_icb_rsp_err,
    output logic [31:0]       i_icb_rsp_rdata,
    output logic              o_done,
    output logic              o_pass,
    output logic [30:0]       o_exit_code,
    output logic [CNT_W-1:0]  o_tohost_cnt
);

    rsp_state_e  state_q, state_d;
    logic [31:0] tohost, fromhost, cycle, status, rdata_d;
    logic [11:0] off;
    logic        accept, is_th, is_fh, is_cy, is_st, err_d, wr_th, wr_fh, end_wr;
    logic        unused_addr;

    assign unused_addr = ^i_icb_cmd_addr[ADDR_W-1:12];
    assign off         = i_icb_cmd_addr[11:0];

    // Exact offset compares also reject misaligned addresses
    assign is_th = off == OFF_TOHOST;
    assign is_fh = off == OFF_FROMHOST;
    assign is_cy = off == OFF_CYCLE;
    assign is_st = off == OFF_STATUS;

    assign i_icb_rsp_valid = state_q == ST_RSP;
    assign i_icb_cmd_ready = ~i_icb_rsp_valid | i_icb_rsp_ready;
    assign accept          = i_icb_cmd_valid & i_icb_cmd_ready;

    always_comb begin
        status = '0;
        status[STATUS_CNT_LSB +: 16]  = 16'(o_tohost_cnt);
        status[STATUS_FAIL_BIT]       = ~o_pass & o_done;
        status[STATUS_DONE_BIT]       = o_done;
    end

    assign err_d = ~(is_th | is_fh | is_cy | is_st)
                 | (~i_icb_cmd_read & (is_cy | is_st))
                 | (~i_icb_cmd_read & is_th & (i_icb_cmd_wmask != 4'hF));

    assign rdata_d = (~i_icb_cmd_read | err_d) ? 32'd0 :
                     is_th ? tohost :
                     is_fh ? fromhost :
                     is_cy ? cycle : status;

    assign wr_th  = accept & ~i_icb_cmd_read & is_th & ~err_d;
    assign wr_fh  = accept & ~i_icb_cmd_read & is_fh;
    assign end_wr = wr_th & i_icb_cmd_wdata[0] & ~o_done;

    // A fresh acceptance always (re)loads RSP, covering the back-to-back case
    always_comb begin
        state_d = state_q;
        state_d = accept ? ST_RSP : (i_icb_rsp_ready ? ST_IDLE : state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            i_icb_rsp_err   <= 1'b0;
            i_icb_rsp_rdata <= '0;
            tohost          <= '0;
            fromhost        <= '0;
            cycle           <= '0;
            o_done          <= 1'b0;
            o_pass          <= 1'b0;
            o_exit_code     <= '0;
            o_tohost_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                i_icb_rsp_err   <= err_d;
                i_icb_rsp_rdata <= rdata_d;
            end
            if (wr_th) begin
                tohost       <= i_icb_cmd_wdata;
                o_tohost_cnt <= &o_tohost_cnt ? o_tohost_cnt : o_tohost_cnt + 1'b1;
            end
            if (wr_fh) fromhost <= byte_merge(fromhost, i_icb_cmd_wdata, i_icb_cmd_wmask);
            if (!o_done) cycle <= cycle + 32'd1;
            if (end_wr) begin
                o_done      <= 1'b1;
                o_exit_code <= i_icb_cmd_wdata[31:1];
                o_pass      <= i_icb_cmd_wdata[31:1] == 31'd0;
            end
        end
    end

endmodule

// File: tb/tb_e203_subsys_tohost.sv
// tb_e203_subsys_tohost: directed table, corner sequences and random traffic against a register-map model
module tb_e203_subsys_tohost;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b1;
    logic [31:0]      cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]       cmd_wmask = '0;
    logic             rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0]      rsp_rdata;
    logic             done, pass;
    logic [30:0]      exit_code;
    logic [CNT_W-1:0] tohost_cnt;

    e203_subsys_tohost #(.ADDR_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready),
        .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read),
        .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
        .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready),
        .i_icb_rsp_err(rsp_err), .i_icb_rsp_rdata(rsp_rdata),
        .o_done(done), .o_pass(pass), .o_exit_code(exit_code), .o_tohost_cnt(tohost_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Clocks elapsed since reset release: the time base CYCLE should follow
    int clk_n;
    always @(posedge clk or posedge rst) clk_n <= rst ? 0 : clk_n + 1;

    logic [31:0] m_th, m_fh, m_frz;
    logic        m_done, m_pass;
    logic [30:0] m_exit;
    int          m_cnt;

    task automatic model_clear();
        m_th = 0; m_fh = 0; m_frz = 0; m_done = 0; m_pass = 0; m_exit = 0; m_cnt = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval(input logic rd, input logic [31:0] a, input logic [3:0] wm,
                              input int c, output logic e, output logic [31:0] r);
        int idx;
        logic [31:0] st;
        idx = (a[1:0] != 0) ? 99 : int'(a[11:0]) / 4;
        st  = {16'(m_cnt), 14'b0, ~m_pass & m_done, m_done};
        e   = idx > 3 || (!rd && idx >= 2) || (!rd && idx == 0 && wm != 4'hF);
        r   = 0;
        if (rd && !e)
            case (idx)
                0: r = m_th;
                1: r = m_fh;
                2: r = m_done ? m_frz : c;
                default: r = st;
            endcase
    endtask

    task automatic model_apply(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] wm, input logic e);
        if (rd || e) return;
        if (a[11:0] == 12'h000) begin
            m_th  = wd;
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (wd[0] && !m_done) begin
                m_done = 1; m_exit = wd[31:1]; m_pass = (wd[31:1] == 0); m_frz = clk_n;
            end
        end else
            for (int b = 0; b < 4; b++) if (wm[b]) m_fh[8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic chk_flags();
        chk("o_done", done, m_done);
        chk("o_pass", pass, m_pass);
        chk("o_exit_code", exit_code, m_exit);
        chk("o_tohost_cnt", tohost_cnt, m_cnt);
    endtask

    task automatic xact(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, output logic e, output logic [31:0] r);
        logic xe;
        logic [31:0] xr;
        @(negedge clk);
        cmd_valid = 1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm; rsp_ready = 1;
        model_eval(rd, a, wm, clk_n, xe, xr);
        @(posedge clk);
        #1;
        cmd_valid = 0;
        model_apply(rd, a, wd, wm, xe);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, xe);
        chk("rsp_rdata", rsp_rdata, xr);
        chk_flags();
        e = rsp_err; r = rsp_rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 0; rst = 1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_done_pass", {done, pass}, 0);
        chk("rst_exit_code", exit_code, 0);
        chk("rst_cnt", tohost_cnt, 0);
        repeat (2) @(posedge clk);
        #2 rst = 0;
        model_clear();
        @(posedge clk);
        #1 chk("cmd_ready_after_rst", cmd_ready, 1);
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic e;
        logic [31:0] r, r0, exp_b;
        logic [31:0] burst[4];
        logic [31:0] alist[8];
        logic [31:0] a, wd;
        logic [3:0]  wm;
        logic        rd, xe;

        tbl = '{
            '{1, 32'h000, 32'h0,        4'h0, 0, 32'h0},
            '{0, 32'h004, 32'hAABBCCDD, 4'h5, 0, 32'h0},
            '{1, 32'h004, 32'h0,        4'h0, 0, 32'h00BB00DD},
            '{1, 32'h010, 32'h0,        4'h0, 1, 32'h0},
            '{0, 32'h008, 32'h12345678, 4'hF, 1, 32'h0},
            '{1, 32'h002, 32'h0,        4'h0, 1, 32'h0},
            '{0, 32'h00C, 32'hFFFFFFFF, 4'hF, 1, 32'h0},
            '{0, 32'h000, 32'h00000001, 4'h7, 1, 32'h0},
            '{1, 32'h00C, 32'h0,        4'h0, 0, 32'h0},
            '{0, 32'h000, 32'h00000007, 4'hF, 0, 32'h0},
            '{1, 32'h00C, 32'h0,        4'h0, 0, 32'h00010003},
            '{0, 32'h000, 32'h00000001, 4'hF, 0, 32'h0},
            '{1, 32'h000, 32'h0,        4'h0, 0, 32'h00000001},
            '{1, 32'h00C, 32'h0,        4'h0, 0, 32'h00020003}
        };
        alist = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h002, 32'hFFC, 32'h1005};

        model_clear();
        do_reset();

        foreach (tbl[i]) begin
            xact(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, e, r);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].err);
            chk($sformatf("tbl%0d_rdata", i), r, tbl[i].rdata);
        end
        chk("fail_exit_code", exit_code, 3);
        chk("fail_pass", pass, 0);
        chk("fail_cnt", tohost_cnt, 2);

        do_reset();
        xact(0, 32'h000, 32'h1, 4'hF, e, r);
        chk("pass_err", e, 0);
        chk("pass_flags", {done, pass, tohost_cnt}, {2'b11, 3'd1});
        chk("pass_exit", exit_code, 0);

        // Stall: response held while a second command waits
        @(negedge clk);
        cmd_valid = 1; cmd_read = 1; cmd_addr = 32'h004; rsp_ready = 0;
        model_eval(1, 32'h004, 4'h0, clk_n, xe, r0);
        burst = '{32'h000, 32'h004, 32'h00C, 32'h008};
        @(posedge clk);
        #1 cmd_addr = burst[0];
        chk("stall_first_rdata", rsp_rdata, r0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_cmd_ready", cmd_ready, 0);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rdata", rsp_rdata, r0);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            cmd_valid = 1; cmd_addr = burst[k]; rsp_ready = 1;
            model_eval(1, burst[k], 4'h0, clk_n, xe, exp_b);
            @(posedge clk);
            #1;
            chk("burst_rsp_valid", rsp_valid, 1);
            chk("burst_rdata", rsp_rdata, exp_b);
        end
        cmd_valid = 0;

        do_reset();
        for (int n = 0; n < 400; n++) begin
            a  = alist[$urandom_range(0, 7)] | ($urandom & 32'hFFFF_F000);
            rd = 1'($urandom_range(0, 1));
            wd = $urandom & 32'hFFFF_FFFE;
            if ($urandom_range(0, 7) == 0) wd[0] = 1;
            wm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            xact(rd, a, wd, wm, e, r);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Reset while a response is pending
        @(negedge clk);
        cmd_valid = 1; cmd_read = 1; cmd_addr = 32'h004; rsp_ready = 0;
        @(posedge clk);
        #1 cmd_valid = 0;
        chk("pre_rst_rsp_valid", rsp_valid, 1);
        #2 rst = 1;
        #1 chk("rst_drops_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #2 rst = 0;
        model_clear();
        xact(1, 32'h008, 32'h0, 4'h0, e, r);
        chk("cycle_after_rst", r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e203_subsys_tohost.md
E203_SUBSYS_TOHOST -- requirements
Module: e203_subsys_tohost

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, ICB command address width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the tohost write counter.
REQ-003 SHALL have one clock and one reset: asynchronous, active-high reset.
REQ-004 clk  input  1  core clock (hfclk domain).
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 i_icb_cmd_valid  input  1  ICB command valid.
REQ-007 i_icb_cmd_ready  output  1  ICB command ready.
REQ-008 i_icb_cmd_addr  input  ADDR_W  byte address; only bits [11:0] are decoded.
REQ-009 i_icb_cmd_read  input  1  1 = read, 0 = write.
REQ-010 i_icb_cmd_wdata  input  32  write data.
REQ-011 i_icb_cmd_wmask  input  4  byte-enable mask.
REQ-012 i_icb_rsp_valid  output  1  response valid.
REQ-013 i_icb_rsp_ready  input  1  response ready.
REQ-014 i_icb_rsp_err  output  1  response error.
REQ-015 i_icb_rsp_rdata  output  32  read data.
REQ-016 o_done  output  1  sticky test-end flag.
REQ-017 o_pass  output  1  valid when o_done; 1 = exit code 0.
REQ-018 o_exit_code  output  31  latched wdata[31:1] of the ending write.
REQ-019 o_tohost_cnt  output  CNT_W  count of accepted full-word TOHOST writes.

Function
REQ-020 Register map SHALL be:
- 0x000 TOHOST, RW.
- 0x004 FROMHOST, RW, byte-masked.
- 0x008 CYCLE, RO.
- 0x00C STATUS, RO: {o_tohost_cnt zero-extended to [31:16], 14'b0, ~o_pass&o_done, o_done}.
REQ-021 Any other offset, a nonzero addr[1:0], or a write to CYCLE/STATUS SHALL respond with err=1 and rdata=0, with no state change.
REQ-022 A TOHOST write with wmask!=4'hF SHALL respond with err=1 and no state change.
REQ-023 Handshake: a command is accepted when cmd_valid&cmd_ready; cmd_ready = ~rsp_valid | rsp_ready.
REQ-024 Response SHALL be registered: rsp_valid rises the cycle after acceptance and holds, with stable rdata/err, until rsp_valid&rsp_ready.
REQ-025 If a response handshake and a new acceptance occur in the same cycle, the new response SHALL load and rsp_valid SHALL stay 1 (back-to-back, one transaction per cycle).
REQ-026 The response FSM SHALL have two states:
- IDLE→RSP on acceptance.
- RSP→IDLE on rsp_ready without a new acceptance.
- RSP→RSP on rsp_ready with a new acceptance.
REQ-027 Register writes SHALL take effect in the acceptance cycle; a read in the next accepted command returns the new value.
REQ-028 A full TOHOST write SHALL increment o_tohost_cnt, saturating at all-ones (no wrap).
REQ-029 A full TOHOST write with wdata[0]=1 while o_done=0 SHALL set o_done=1, latch o_exit_code=wdata[31:1], and set o_pass=(wdata[31:1]==0).
REQ-030 Subsequent ending writes SHALL NOT alter o_done, o_pass or o_exit_code, but SHALL update TOHOST and the count.
REQ-031 CYCLE SHALL increment by 1 every clock from reset, wrapping at 2^32, and SHALL freeze from the cycle after o_done sets.
REQ-032 FROMHOST SHALL update only the bytes enabled by wmask.

Reset
REQ-033 On rst, all of the following SHALL be 0:
- rsp_valid, rsp_err, rsp_rdata;
- TOHOST, FROMHOST, CYCLE;
- o_done, o_pass, o_exit_code, o_tohost_cnt.
REQ-034 i_icb_cmd_ready SHALL be 1 one cycle after reset deasserts.
REQ-035 Reset asserted mid-response SHALL drop rsp_valid immediately; the pending response is discarded.

Structure
REQ-036 Register offsets, STATUS bit positions and the FSM state encoding SHALL live in the shared e203 defines package.
REQ-037 The block SHALL be a single module; no sub-module is required.

Verification
REQ-038 Write TOHOST=0x0000_0001 (mask F) → rsp err=0; o_done=1, o_pass=1, o_exit_code=0, o_tohost_cnt=1.
REQ-039 Write TOHOST=0x0000_0007 → o_done=1, o_pass=0, o_exit_code=3, STATUS[1:0]=2'b11; a second write of 0x1 leaves o_exit_code=3 and sets o_tohost_cnt=2.
REQ-040 Write FROMHOST=0xAABBCCDD mask 4'b0101, then read it → rdata=0x00BB00DD, err=0.
REQ-041 Read 0x010, write CYCLE, and read 0x002 → each gives err=1, rdata=0, and registers unchanged.
REQ-042 Hold rsp_ready=0 for 5 cycles with cmd_valid=1 → cmd_ready=0 and rdata stable; then a back-to-back burst of 4 reads with rsp_ready=1 → 4 responses in 4 consecutive cycles.
REQ-043 Assert rst while rsp_valid=1 → rsp_valid=0 in the same cycle; CYCLE reads 0 after release.
